// File: rtl/core_ifetch_pkg.sv
// Shared types and constants for the instruction prefetcher.
// An instruction buffer entry holds the fetched word, its PC and its error flag.
package core_ifetch_pkg;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [31:0] INSTR_RESET = 32'hDEADBEEF;
   localparam int          INSTR_W     = 32;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [31:0]        pc;
      logic               err;
   } entry_t;

   localparam entry_t ENTRY_RESET = '{instr: INSTR_RESET, pc: 32'h0, err: 1'b0};

endpackage

// File: rtl/core_ifetch_fifo.sv
// Instruction buffer with a synchronous flush, a registered head and an occupancy count.
// A push into an empty buffer goes straight to the head register.
module core_ifetch_fifo
   import core_ifetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                 CLK,
   input  logic                 NRST,
   input  logic                 flush,
   input  logic                 push,
   input  entry_t               din,
   input  logic                 pop,
   output logic                 head_valid,
   output entry_t               head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_ptr_nxt;
   logic [AW:0]   count_after_pop;
   logic [AW:0]   count_nxt;
   logic          push_ok;
   logic          pop_ok;
   entry_t        head_nxt;

   always_comb begin
      pop_ok          = pop && head_valid;
      push_ok         = push && ((count != FULL) || pop_ok);
      count_after_pop = count - (AW+1)'(pop_ok);
      count_nxt       = count_after_pop + (AW+1)'(push_ok);
      rd_ptr_nxt      = rd_ptr + AW'(pop_ok);
      if (push_ok && (count_after_pop == '0)) begin
         head_nxt = din;
      end else begin
         head_nxt = mem[rd_ptr_nxt];
      end
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         head_valid <= 1'b0;
         head       <= ENTRY_RESET;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         head_valid <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         rd_ptr     <= rd_ptr_nxt;
         count      <= count_nxt;
         head_valid <= (count_nxt != '0);
         // head keeps its last word while empty
         if (count_nxt != '0) begin
            head <= head_nxt;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (push_ok && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/core_ifetch_prefetch.sv
// Pipelined instruction prefetcher: credit-based AR issue, issued-PC tracking,
// stale-response discard on redirect, and a buffered valid/ready stream to decode.
module core_ifetch_prefetch
   import core_ifetch_pkg::*;
#(
   parameter logic [31:0] PC_INIT         = 32'h0,
   parameter int          AXI_AWIDTH      = 4,
   parameter int          AXI_DWIDTH      = 32,
   parameter int          FIFO_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic                  CLK,
   input  logic                  NRST,
   output logic [AXI_AWIDTH-1:0] AXI_ARADDR,
   output logic                  AXI_ARVALID,
   input  logic                  AXI_ARREADY,
   input  logic [AXI_DWIDTH-1:0] AXI_RDATA,
   input  logic [1:0]            AXI_RRESP,
   input  logic                  AXI_RVALID,
   output logic                  AXI_RREADY,
   input  logic                  C_FETCH_EN,
   input  logic                  C_PC_UPDATE,
   input  logic [31:0]           PC_NEXT,
   output logic                  INSTR_VALID,
   input  logic                  INSTR_READY,
   output logic [31:0]           INSTRUCTION,
   output logic [31:0]           INSTR_PC,
   output logic                  INSTR_ERR,
   output logic [31:0]           FETCH_PC
);

   localparam int CW  = $clog2(FIFO_DEPTH) + 2;
   localparam int FCW = $clog2(FIFO_DEPTH) + 1;
   localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [PW-1:0] PQ_LAST = PW'(MAX_OUTSTANDING - 1);
   localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic           arvalid_q;
   logic           rready_q;
   logic           redir_pend_q;
   logic [31:0]    fetch_pc_q;
   logic [31:0]    redir_pc_q;
   logic [31:0]    pc_next_al;
   logic [CW-1:0]  outst_q;
   logic [CW-1:0]  discard_q;
   logic [CW-1:0]  outst_nxt;
   logic [CW-1:0]  discard_nxt;
   logic [CW-1:0]  fifo_cnt_nxt;
   logic [FCW-1:0] fifo_count;
   logic [31:0]    pcq [MAX_OUTSTANDING];
   logic [PW-1:0]  pq_wr_q;
   logic [PW-1:0]  pq_rd_q;
   logic           ar_hs;
   logic           ar_stall;
   logic           r_hs;
   logic           pop;
   logic           push;
   logic           arvalid_nxt;
   entry_t         push_entry;
   entry_t         head;

   always_comb begin
      ar_hs        = arvalid_q && AXI_ARREADY;
      ar_stall     = arvalid_q && !AXI_ARREADY;
      r_hs         = AXI_RVALID && rready_q;
      pop          = INSTR_VALID && INSTR_READY;
      pc_next_al   = PC_NEXT & ~32'h3;
      push         = r_hs && (discard_q == '0) && !C_PC_UPDATE;
      push_entry   = '{instr: AXI_RDATA, pc: pcq[pq_rd_q], err: (AXI_RRESP != RESP_OKAY)};
      outst_nxt    = outst_q + CW'(ar_hs) - CW'(r_hs);
      fifo_cnt_nxt = C_PC_UPDATE ? '0 : (CW'(fifo_count) + CW'(push) - CW'(pop));
      // everything still in flight after a redirect is stale, including an unaccepted AR
      if (C_PC_UPDATE) begin
         discard_nxt = outst_nxt + CW'(ar_stall);
      end else begin
         discard_nxt = discard_q - CW'(r_hs && (discard_q != '0));
      end
      if (ar_stall) begin
         arvalid_nxt = 1'b1;
      end else begin
         arvalid_nxt = C_FETCH_EN && (outst_nxt < MAX_OUT) &&
                       ((outst_nxt + fifo_cnt_nxt) < DEPTH_C);
      end
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         redir_pend_q <= 1'b0;
         fetch_pc_q   <= PC_INIT;
         redir_pc_q   <= PC_INIT;
         outst_q      <= '0;
         discard_q    <= '0;
         pq_wr_q      <= '0;
         pq_rd_q      <= '0;
      end else begin
         arvalid_q <= arvalid_nxt;
         rready_q  <= 1'b1;
         outst_q   <= outst_nxt;
         discard_q <= discard_nxt;
         if (ar_hs) begin
            pq_wr_q <= (pq_wr_q == PQ_LAST) ? '0 : pq_wr_q + PW'(1);
         end
         if (r_hs) begin
            pq_rd_q <= (pq_rd_q == PQ_LAST) ? '0 : pq_rd_q + PW'(1);
         end
         // a redirect during a stalled AR is parked until that AR is accepted
         if (ar_hs) begin
            redir_pend_q <= 1'b0;
            if (C_PC_UPDATE) begin
               fetch_pc_q <= pc_next_al;
            end else if (redir_pend_q) begin
               fetch_pc_q <= redir_pc_q;
            end else begin
               fetch_pc_q <= fetch_pc_q + 32'd4;
            end
         end else if (C_PC_UPDATE) begin
            if (arvalid_q) begin
               redir_pend_q <= 1'b1;
               redir_pc_q   <= pc_next_al;
            end else begin
               fetch_pc_q <= pc_next_al;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (ar_hs) begin
         pcq[pq_wr_q] <= fetch_pc_q;
      end
   end

   core_ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .CLK        (CLK),
      .NRST       (NRST),
      .flush      (C_PC_UPDATE),
      .push       (push),
      .din        (push_entry),
      .pop        (pop),
      .head_valid (INSTR_VALID),
      .head       (head),
      .count      (fifo_count)
   );

   assign AXI_ARADDR  = fetch_pc_q[AXI_AWIDTH-1:0];
   assign AXI_ARVALID = arvalid_q;
   assign AXI_RREADY  = rready_q;
   assign FETCH_PC    = fetch_pc_q;
   assign INSTRUCTION = head.instr;
   assign INSTR_PC    = head.pc;
   assign INSTR_ERR   = head.err;

endmodule

// File: tb/tb_core_ifetch_prefetch.sv
// Scoreboard bench for the prefetcher: a memory model answers ARs, expected words
// are queued when R beats are driven and compared when decode pops them.
module tb_core_ifetch_prefetch;
   import core_ifetch_pkg::*;

   localparam int          AW      = 4;
   localparam int          DEPTH   = 4;
   localparam int          MAXO    = 2;
   localparam logic [31:0] PC_INIT = 32'h0;

   logic          CLK = 1'b0;
   logic          NRST;
   logic [AW-1:0] AXI_ARADDR;
   logic          AXI_ARVALID;
   logic          AXI_ARREADY;
   logic [31:0]   AXI_RDATA;
   logic [1:0]    AXI_RRESP;
   logic          AXI_RVALID;
   logic          AXI_RREADY;
   logic          C_FETCH_EN;
   logic          C_PC_UPDATE;
   logic [31:0]   PC_NEXT;
   logic          INSTR_VALID;
   logic          INSTR_READY;
   logic [31:0]   INSTRUCTION;
   logic [31:0]   INSTR_PC;
   logic          INSTR_ERR;
   logic [31:0]   FETCH_PC;

   core_ifetch_prefetch #(
      .PC_INIT(PC_INIT), .AXI_AWIDTH(AW), .AXI_DWIDTH(32),
      .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .CLK(CLK), .NRST(NRST),
      .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
      .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID),
      .AXI_RREADY(AXI_RREADY), .C_FETCH_EN(C_FETCH_EN), .C_PC_UPDATE(C_PC_UPDATE),
      .PC_NEXT(PC_NEXT), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
      .INSTRUCTION(INSTRUCTION), .INSTR_PC(INSTR_PC), .INSTR_ERR(INSTR_ERR),
      .FETCH_PC(FETCH_PC)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] pc;
      bit          stale;
      int          t;
   } req_t;

   req_t        memq[$];
   entry_t      sb[$];
   int          n_total = 0;
   int          n_bad   = 0;
   int          cyc     = 0;
   int          lat     = 1;
   int          n_ar    = 0;
   int          n_pop   = 0;
   int          mark;
   logic [31:0] exp_pc;
   logic [31:0] pend_target;
   logic [31:0] err_pc;
   logic [31:0] watch_pc;
   logic [31:0] redir_raw;
   logic [AW-1:0] prev_addr;
   bit          pend_stale, pend_redir, watch_on, redir_req;
   bit          arready_en, ready_en, rand_mode, first_chk, prev_pend;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_data(input logic [31:0] pc);
      return (pc * 32'h9E3779B1) ^ 32'h1234_5678;
   endfunction

   task automatic model_reset();
      memq.delete();
      sb.delete();
      exp_pc      = PC_INIT;
      pend_stale  = 0;
      pend_redir  = 0;
      watch_on    = 0;
      prev_pend   = 0;
      redir_req   = 0;
      AXI_RVALID  = 0;
      C_PC_UPDATE = 0;
   endtask

   task automatic chk_reset_vals();
      chk("rst_arvalid", 32'(AXI_ARVALID), 32'd0);
      chk("rst_rready",  32'(AXI_RREADY),  32'd0);
      chk("rst_ivalid",  32'(INSTR_VALID), 32'd0);
      chk("rst_instr",   INSTRUCTION,      32'hDEADBEEF);
      chk("rst_ipc",     INSTR_PC,         32'h0);
      chk("rst_ierr",    32'(INSTR_ERR),   32'd0);
      chk("rst_fpc",     FETCH_PC,         PC_INIT);
   endtask

   // One clock: drive inputs at the falling edge and account for the handshakes
   // that will complete at the next rising edge.
   task automatic step();
      entry_t e;
      req_t   r;
      @(negedge CLK);
      cyc++;
      if (first_chk) begin
         chk("arv_first",    32'(AXI_ARVALID), 32'd1);
         chk("araddr_first", 32'(AXI_ARADDR),  32'(exp_pc[AW-1:0]));
         chk("rready_first", 32'(AXI_RREADY),  32'd1);
         first_chk = 0;
      end
      if (prev_pend) begin
         chk("arv_hold",    32'(AXI_ARVALID), 32'd1);
         chk("araddr_hold", 32'(AXI_ARADDR),  32'(prev_addr));
      end
      if (rand_mode) begin
         arready_en = ($urandom_range(0, 3) != 0);
         ready_en   = ($urandom_range(0, 2) != 0);
         lat        = $urandom_range(1, 3);
         if ($urandom_range(0, 29) == 0) begin
            redir_req = 1;
            redir_raw = $urandom;
         end
      end
      INSTR_READY = ready_en;
      AXI_ARREADY = arready_en;

      chk("valid", 32'(INSTR_VALID), 32'(sb.size() != 0));
      if (INSTR_VALID && INSTR_READY && sb.size() != 0) begin
         e = sb.pop_front();
         chk("instr", INSTRUCTION,    e.instr);
         chk("ipc",   INSTR_PC,       e.pc);
         chk("ierr",  32'(INSTR_ERR), 32'(e.err));
         n_pop++;
         if (watch_on) begin
            chk("first_pc_after_redir", INSTR_PC, watch_pc);
            watch_on = 0;
         end
      end

      AXI_RVALID = 0;
      AXI_RRESP  = 2'b00;
      AXI_RDATA  = '0;
      if (memq.size() != 0 && (cyc - memq[0].t) >= lat) begin
         AXI_RVALID = 1;
         AXI_RDATA  = mem_data(memq[0].pc);
         AXI_RRESP  = (memq[0].pc == err_pc) ? 2'b10 : 2'b00;
         chk("rready", 32'(AXI_RREADY), 32'd1);
         if (AXI_RREADY) begin
            r = memq.pop_front();
            if (!r.stale) begin
               e.instr = mem_data(r.pc);
               e.pc    = r.pc;
               e.err   = (r.pc == err_pc);
               sb.push_back(e);
            end
         end
      end

      if (AXI_ARVALID && AXI_ARREADY) begin
         chk("araddr",   32'(AXI_ARADDR), 32'(exp_pc[AW-1:0]));
         chk("fetch_pc", FETCH_PC,        exp_pc);
         r.pc    = exp_pc;
         r.stale = pend_stale;
         r.t     = cyc;
         memq.push_back(r);
         n_ar++;
         pend_stale = 0;
         if (pend_redir) begin
            exp_pc     = pend_target;
            pend_redir = 0;
         end else begin
            exp_pc = exp_pc + 32'd4;
         end
      end

      C_PC_UPDATE = 0;
      if (redir_req) begin
         C_PC_UPDATE = 1;
         PC_NEXT     = redir_raw;
         redir_req   = 0;
         foreach (memq[i]) memq[i].stale = 1;
         sb.delete();
         if (AXI_ARVALID && !AXI_ARREADY) begin
            pend_stale  = 1;
            pend_redir  = 1;
            pend_target = redir_raw & ~32'h3;
         end else begin
            exp_pc = redir_raw & ~32'h3;
         end
         watch_on = 1;
         watch_pc = redir_raw & ~32'h3;
      end
      prev_pend = AXI_ARVALID && !AXI_ARREADY;
      prev_addr = AXI_ARADDR;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic async_reset();
      @(posedge CLK);
      #2;
      NRST = 0;
      #1;
      chk_reset_vals();
      model_reset();
      @(negedge CLK);
      @(negedge CLK);
      NRST      = 1;
      first_chk = 1;
   endtask

   initial begin
      NRST        = 1;
      AXI_ARREADY = 0;
      AXI_RDATA   = '0;
      AXI_RRESP   = 2'b00;
      AXI_RVALID  = 0;
      C_FETCH_EN  = 1;
      C_PC_UPDATE = 0;
      PC_NEXT     = '0;
      INSTR_READY = 0;
      arready_en  = 1;
      ready_en    = 1;
      rand_mode   = 0;
      err_pc      = 32'h8;
      model_reset();
      #1 NRST = 0;
      #2 chk_reset_vals();
      @(negedge CLK);
      @(negedge CLK);
      NRST      = 1;
      first_chk = 1;

      // streaming from reset; the word at 0x8 carries an error response
      run(4);
      mark = n_ar;
      n_pop = 0;
      run(16);
      chk("b2b_ar",  32'(n_ar - mark), 32'd16);
      chk("no_gaps", 32'(n_pop),       32'd16);

      // decode stalled: buffer fills to its depth and issue stops
      ready_en = 0;
      run(20);
      chk("stall_fill", 32'(sb.size()),   32'(DEPTH));
      chk("stall_arv",  32'(AXI_ARVALID), 32'd0);
      ready_en = 1;
      run(10);

      // fetch disabled: in-flight and buffered words still drain
      C_FETCH_EN = 0;
      run(10);
      chk("fen_arv",   32'(AXI_ARVALID), 32'd0);
      chk("fen_drain", 32'(sb.size() + memq.size()), 32'd0);
      C_FETCH_EN = 1;

      // redirect with two requests in flight
      lat = 4;
      for (int i = 0; i < 50 && memq.size() != 2; i++) step();
      chk("outst2", 32'(memq.size()), 32'd2);
      redir_req = 1;
      redir_raw = 32'h100;
      run(30);
      chk("redir_seen", 32'(watch_on), 32'd0);
      lat = 1;

      // redirect while an AR is stalled; unaligned target gets aligned
      arready_en = 0;
      for (int i = 0; i < 20 && !AXI_ARVALID; i++) step();
      chk("arv_pend", 32'(AXI_ARVALID), 32'd1);
      redir_req = 1;
      redir_raw = 32'h102;
      run(3);
      arready_en = 1;
      run(30);
      chk("redir2_seen", 32'(watch_on), 32'd0);

      // asynchronous reset in the middle of a burst
      lat = 2;
      run(5);
      async_reset();
      run(12);

      // mixed random traffic with occasional redirects
      rand_mode = 1;
      run(400);
      rand_mode  = 0;
      arready_en = 1;
      ready_en   = 1;
      lat        = 1;
      C_FETCH_EN = 0;
      run(20);
      chk("final_drain", 32'(sb.size() + memq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
